hazard_forward_unit: RTL and testbench
======================================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have parameter REG_W, default 5: register index width.
REQ-002 SHALL have parameter MUL_LAT, default 4, legal >=1: multicycle op residency in Execute, in cycles.
REQ-003 SHALL have parameter FLUSH_CYCLES, default 1, legal >=1: cycles Fetch/Decode flush is held per taken jump.
REQ-004 SHALL have parameter CNT_W, default 16: stall counter width.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 d_src_reg_1, d_src_reg_2  in  REG_W  Decode source indices.
REQ-008 x_src_reg_1, x_src_reg_2  in  REG_W  Execute source indices.
REQ-009 x_dst_reg, m_dst_reg, w_dst_reg  in  REG_W  Execute/Memory/Writeback destination indices.
REQ-010 x_reg_write, m_reg_write, w_reg_write  in  1  stage writes a register.
REQ-011 x_mem_read  in  1  Execute holds a load.
REQ-012 x_mul_start  in  1  Execute holds a multicycle op; held high while the op sits in Execute.
REQ-013 pc_src  in  2  PC source select; taken jump = pc_src[1] XOR pc_src[0].
REQ-014 stat_clear  in  1  clears stall_count.
REQ-015 f_stall, d_stall, x_stall, m_stall  out  1  stage stall flags; m_stall is constant 0.
REQ-016 f_flush, d_flush  out  1  Fetch/Decode flush flags.
REQ-017 x_fwd_a, x_fwd_b  out  2  Execute operand source: 00 regfile, 01 Memory-stage result, 10 Writeback-stage result; 11 never driven.
REQ-018 stall_count  out  CNT_W  saturating count of cycles with d_stall=1.

Function
REQ-019 Stage match SHALL require: index equal, stage reg_write=1, stage dst != 0.
REQ-020 x_fwd_a SHALL be 01 if x_src_reg_1 matches Memory, else 10 if it matches Writeback, else 00; x_fwd_b likewise from x_src_reg_2; Memory wins when both match (combinational, 0 latency).
REQ-021 load_use SHALL be x_mem_read AND (d_src_reg_1 or d_src_reg_2 matches Execute); all other data hazards SHALL be covered by forwarding with no stall.
REQ-022 Multicycle FSM SHALL have states IDLE and BUSY with down-counter mcnt.
REQ-023 IDLE with x_mul_start=1 and MUL_LAT>1: mul_stall=1, next BUSY, mcnt <= MUL_LAT-2.
REQ-024 BUSY: mul_stall = (mcnt!=0); mcnt decrements while nonzero; mcnt==0 -> IDLE; x_mul_start ignored in BUSY.
REQ-025 Each multicycle op SHALL stall exactly MUL_LAT-1 cycles; MUL_LAT=1 never stalls and FSM stays IDLE; back-to-back ops each get the full stall.
REQ-026 x_stall SHALL equal mul_stall.
REQ-027 Taken jump SHALL assert f_flush and d_flush the same cycle and load fcnt <= FLUSH_CYCLES-1; flush stays asserted while fcnt != 0, fcnt decrementing each cycle.
REQ-028 A taken jump during an active flush window SHALL reload fcnt (window restarts).
REQ-029 d_stall SHALL be x_stall OR (load_use AND NOT f_flush); f_stall SHALL equal d_stall.
REQ-030 stall_count SHALL increment on each cycle with d_stall=1, saturate at all-ones, and clear to 0 when stat_clear=1 (clear wins over increment).

Reset
REQ-031 reset=1 SHALL force FSM IDLE, mcnt=0, fcnt=0, stall_count=0 at next edge, overriding all inputs, including mid-BUSY and mid-flush.
REQ-032 During and after reset, combinational outputs SHALL depend only on current inputs and reset state; with all inputs 0 every output SHALL be 0.

Verification
REQ-033 m_dst=3,m_wr=1,w_dst=3,w_wr=1,x_src1=3 -> x_fwd_a=01; m_wr=0 -> 10; m_dst=w_dst=0 -> 00.
REQ-034 x_mem_read=1,x_dst=7,x_wr=1,d_src2=7 -> d_stall=f_stall=1 one cycle, stall_count 0->1; x_dst=0 -> no stall.
REQ-035 MUL_LAT=4, x_mul_start held -> x_stall=d_stall=1 for exactly 3 cycles, 0 on 4th; second op immediately -> 3 more stall cycles.
REQ-036 FLUSH_CYCLES=2, pc_src=01 one cycle -> f_flush=d_flush=1 for 2 cycles; jump again in 2nd cycle -> 3 cycles total; load_use during flush -> d_stall=0.
REQ-037 reset=1 in 2nd BUSY cycle -> next cycle IDLE, x_stall=0, stall_count=0; CNT_W=2 with 5 stall cycles -> stall_count=3.

Source files
------------

// File: rtl/hazard_forward_unit_if.sv
// hazard_forward_unit_if: pipeline hazard/forwarding signal bundle
interface hazard_forward_unit_if #(
   parameter int REG_W = 5,
   parameter int CNT_W = 16
);
   logic [REG_W-1:0] d_src_reg_1, d_src_reg_2;
   logic [REG_W-1:0] x_src_reg_1, x_src_reg_2;
   logic [REG_W-1:0] x_dst_reg, m_dst_reg, w_dst_reg;
   logic             x_reg_write, m_reg_write, w_reg_write;
   logic             x_mem_read, x_mul_start, stat_clear;
   logic [1:0]       pc_src;
   logic             f_stall, d_stall, x_stall, m_stall;
   logic             f_flush, d_flush;
   logic [1:0]       x_fwd_a, x_fwd_b;
   logic [CNT_W-1:0] stall_count;
   modport master (
      output d_src_reg_1, d_src_reg_2, x_src_reg_1, x_src_reg_2,
      output x_dst_reg, m_dst_reg, w_dst_reg, x_reg_write, m_reg_write, w_reg_write,
      output x_mem_read, x_mul_start, stat_clear, pc_src,
      input  f_stall, d_stall, x_stall, m_stall, f_flush, d_flush, x_fwd_a, x_fwd_b, stall_count
   );
   modport slave (
      input  d_src_reg_1, d_src_reg_2, x_src_reg_1, x_src_reg_2,
      input  x_dst_reg, m_dst_reg, w_dst_reg, x_reg_write, m_reg_write, w_reg_write,
      input  x_mem_read, x_mul_start, stat_clear, pc_src,
      output f_stall, d_stall, x_stall, m_stall, f_flush, d_flush, x_fwd_a, x_fwd_b, stall_count
   );
endinterface

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: operand forwarding, load-use/multicycle stalls, jump flush, stall statistics
module hazard_forward_unit #(
   parameter int REG_W        = 5,
   parameter int MUL_LAT      = 4,
   parameter int FLUSH_CYCLES = 1,
   parameter int CNT_W        = 16
) (
   input logic                   clk,
   input logic                   reset,
   hazard_forward_unit_if.slave  bus
);
   typedef enum logic {IDLE, BUSY} state_t;
   localparam int MW = $clog2(MUL_LAT + 1);
   localparam int FW = $clog2(FLUSH_CYCLES + 1);

   state_t           state_q, state_d;
   logic [MW-1:0]    mcnt_q, mcnt_d;
   logic [FW-1:0]    fcnt_q, fcnt_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;
   logic             m_a, w_a, m_b, w_b, load_use, mul_stall, taken, flush, d_stall;

   function automatic logic hit(input logic [REG_W-1:0] idx, input logic [REG_W-1:0] dst, input logic wr);
      return wr && dst != '0 && idx == dst;
   endfunction

   always_comb begin
      m_a = hit(bus.x_src_reg_1, bus.m_dst_reg, bus.m_reg_write);
      w_a = hit(bus.x_src_reg_1, bus.w_dst_reg, bus.w_reg_write);
      m_b = hit(bus.x_src_reg_2, bus.m_dst_reg, bus.m_reg_write);
      w_b = hit(bus.x_src_reg_2, bus.w_dst_reg, bus.w_reg_write);
      load_use = bus.x_mem_read && (hit(bus.d_src_reg_1, bus.x_dst_reg, bus.x_reg_write) ||
                                    hit(bus.d_src_reg_2, bus.x_dst_reg, bus.x_reg_write));
      state_d = state_q;
      mcnt_d = mcnt_q;
      mul_stall = 1'b0;
      // mcnt counts the stall cycles still owed after the first (IDLE) one
      if (state_q == IDLE) begin
         if (bus.x_mul_start && MUL_LAT > 1) begin
            mul_stall = 1'b1;
            state_d = BUSY;
            mcnt_d = MW'(MUL_LAT - 2);
         end
      end else begin
         mul_stall = mcnt_q != '0;
         if (mul_stall) mcnt_d = mcnt_q - 1'b1;
         else state_d = IDLE;
      end
      taken = ^bus.pc_src;
      flush = taken || fcnt_q != '0;
      fcnt_d = taken ? FW'(FLUSH_CYCLES - 1) : flush ? fcnt_q - 1'b1 : fcnt_q;
      d_stall = mul_stall || (load_use && !flush);
      stall_count_d = bus.stat_clear ? '0 :
                      (d_stall && !(&stall_count_q)) ? stall_count_q + 1'b1 : stall_count_q;
      bus.x_fwd_a = m_a ? 2'b01 : w_a ? 2'b10 : 2'b00;
      bus.x_fwd_b = m_b ? 2'b01 : w_b ? 2'b10 : 2'b00;
      bus.x_stall = mul_stall;
      bus.d_stall = d_stall;
      bus.f_stall = d_stall;
      bus.m_stall = 1'b0;
      bus.f_flush = flush;
      bus.d_flush = flush;
      bus.stall_count = stall_count_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         mcnt_q <= '0;
         fcnt_q <= '0;
         stall_count_q <= '0;
      end else begin
         state_q <= state_d;
         mcnt_q <= mcnt_d;
         fcnt_q <= fcnt_d;
         stall_count_q <= stall_count_d;
      end
   end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed checks of forwarding, stalls, flush, counter and reset
module tb_hazard_forward_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_forward_unit_if #(.REG_W(5), .CNT_W(2)) bus ();

   hazard_forward_unit #(.REG_W(5), .MUL_LAT(4), .FLUSH_CYCLES(2), .CNT_W(2)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.d_src_reg_1 = '0; bus.d_src_reg_2 = '0;
      bus.x_src_reg_1 = '0; bus.x_src_reg_2 = '0;
      bus.x_dst_reg = '0; bus.m_dst_reg = '0; bus.w_dst_reg = '0;
      bus.x_reg_write = 0; bus.m_reg_write = 0; bus.w_reg_write = 0;
      bus.x_mem_read = 0; bus.x_mul_start = 0; bus.stat_clear = 0;
      bus.pc_src = 2'b00;
   endtask

   initial begin
      logic [7:0] pat;
      pat = 8'b0111_0111;
      idle_inputs();
      step(); step();
      #1;
      chk("rst_fwd_a", 16'(bus.x_fwd_a), 0);
      chk("rst_fwd_b", 16'(bus.x_fwd_b), 0);
      chk("rst_stalls", 16'({bus.f_stall, bus.d_stall, bus.x_stall, bus.m_stall}), 0);
      chk("rst_flush", 16'({bus.f_flush, bus.d_flush}), 0);
      chk("rst_count", 16'(bus.stall_count), 0);
      reset = 0;
      step();
      bus.m_dst_reg = 3; bus.m_reg_write = 1; bus.w_dst_reg = 3; bus.w_reg_write = 1;
      bus.x_src_reg_1 = 3; bus.x_src_reg_2 = 3;
      #1;
      chk("fwd_a_mem", 16'(bus.x_fwd_a), 1);
      chk("fwd_b_mem", 16'(bus.x_fwd_b), 1);
      bus.m_reg_write = 0;
      #1;
      chk("fwd_a_wb", 16'(bus.x_fwd_a), 2);
      bus.m_dst_reg = 0; bus.w_dst_reg = 0; bus.m_reg_write = 1;
      #1;
      chk("fwd_a_zero", 16'(bus.x_fwd_a), 0);
      bus.m_dst_reg = 5; bus.w_dst_reg = 3; bus.x_src_reg_2 = 5;
      #1;
      chk("fwd_a_split", 16'(bus.x_fwd_a), 2);
      chk("fwd_b_split", 16'(bus.x_fwd_b), 1);
      chk("fwd_no_stall", 16'(bus.d_stall), 0);
      idle_inputs();
      step();
      bus.x_mem_read = 1; bus.x_dst_reg = 7; bus.x_reg_write = 1; bus.d_src_reg_2 = 7;
      #1;
      chk("lu_d_stall", 16'(bus.d_stall), 1);
      chk("lu_f_stall", 16'(bus.f_stall), 1);
      chk("lu_x_stall", 16'(bus.x_stall), 0);
      step();
      idle_inputs();
      #1;
      chk("lu_released", 16'(bus.d_stall), 0);
      chk("lu_count", 16'(bus.stall_count), 1);
      bus.x_mem_read = 1; bus.x_dst_reg = 0; bus.x_reg_write = 1;
      #1;
      chk("lu_dst0", 16'(bus.d_stall), 0);
      bus.x_dst_reg = 7; bus.d_src_reg_1 = 7; bus.x_reg_write = 0;
      #1;
      chk("lu_nowr", 16'(bus.d_stall), 0);
      idle_inputs();
      bus.stat_clear = 1;
      step();
      bus.stat_clear = 0;
      #1;
      chk("clear_count", 16'(bus.stall_count), 0);
      bus.x_mul_start = 1;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk($sformatf("mul_x_stall_%0d", i), 16'(bus.x_stall), 16'(pat[i]));
         chk($sformatf("mul_d_stall_%0d", i), 16'(bus.d_stall), 16'(pat[i]));
         step();
      end
      bus.x_mul_start = 0;
      #1;
      chk("mul_idle", 16'(bus.x_stall), 0);
      chk("count_sat", 16'(bus.stall_count), 3);
      bus.stat_clear = 1;
      bus.d_src_reg_1 = 1;
      step();
      bus.stat_clear = 0;
      bus.pc_src = 2'b01;
      #1;
      chk("jmp_f_flush_0", 16'(bus.f_flush), 1);
      chk("jmp_d_flush_0", 16'(bus.d_flush), 1);
      step();
      bus.pc_src = 2'b00;
      #1;
      chk("jmp_flush_1", 16'({bus.f_flush, bus.d_flush}), 3);
      step();
      #1;
      chk("jmp_flush_end", 16'({bus.f_flush, bus.d_flush}), 0);
      bus.pc_src = 2'b11;
      #1;
      chk("jmp_not_taken", 16'(bus.f_flush), 0);
      bus.pc_src = 2'b10;
      step();
      bus.pc_src = 2'b01;
      #1;
      chk("rejmp_1", 16'(bus.f_flush), 1);
      step();
      bus.pc_src = 2'b00;
      #1;
      chk("rejmp_2", 16'(bus.f_flush), 1);
      step();
      #1;
      chk("rejmp_end", 16'(bus.f_flush), 0);
      bus.pc_src = 2'b01;
      bus.x_mem_read = 1; bus.x_dst_reg = 7; bus.x_reg_write = 1; bus.d_src_reg_1 = 7;
      #1;
      chk("lu_in_flush", 16'(bus.d_stall), 0);
      step();
      bus.pc_src = 2'b00;
      #1;
      chk("lu_in_flush_tail", 16'(bus.d_stall), 0);
      step();
      #1;
      chk("lu_after_flush", 16'(bus.d_stall), 1);
      idle_inputs();
      bus.stat_clear = 1;
      step();
      bus.stat_clear = 0;
      bus.x_mul_start = 1;
      step();
      step();
      #1;
      chk("pre_rst_busy", 16'(bus.x_stall), 1);
      chk("pre_rst_count", 16'(bus.stall_count), 2);
      reset = 1;
      bus.x_mul_start = 0;
      step();
      reset = 0;
      #1;
      chk("rst_busy_stall", 16'(bus.x_stall), 0);
      chk("rst_busy_count", 16'(bus.stall_count), 0);
      bus.x_mul_start = 1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("post_rst_mul_%0d", i), 16'(bus.x_stall), 16'(pat[i]));
         step();
      end
      bus.x_mul_start = 0;
      bus.pc_src = 2'b10;
      step();
      bus.pc_src = 2'b00;
      reset = 1;
      #1;
      chk("pre_rst_flush", 16'(bus.f_flush), 1);
      step();
      reset = 0;
      #1;
      chk("rst_flush_cleared", 16'(bus.f_flush), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
